sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Parametrised run controller for simulation tops. Replaces the hard-coded reset-after-10-clocks and end-after-N-time logic.
- Generates staggered active-low resets for NUM_DOM domains.
- Counts clock cycles and DUT events, and ends the run on a cycle budget or an external stop request.
- Reports done/timeout status so the top can print statistics and call $finish.

Parameters:
- NUM_DOM, 4: number of reset domains; legal range 1..16.
- HOLD_CYC, 10: cycles all domains stay in reset after start; legal range ≥1.
- STAGGER_CYC, 2: cycles between release of domain k and domain k+1; 0 means all domains release together.
- CNT_W, 32: width of the cycle counter.
- EVT_W, 64: width of the event counter.
- MAX_CYC, 60: run budget in RUN-state cycles; 0 means unlimited.

Ports:
- clk_i  in  1  Single clock.
- reset_i  in  1  Synchronous, active-high reset.
- start_i  in  1  Pulse; begins a run from IDLE.
- pause_i  in  1  While high in RUN, clk_cnt_o and the budget are frozen.
- event_i  in  1  One event per cycle when high.
- stop_req_i  in  1  Request to end the run early.
- dom_reset_n_o  out  NUM_DOM  Per-domain active-low reset.
- running_o  out  1  High in RUN state.
- done_o  out  1  High in DONE state.
- timeout_o  out  1  Sticky; set when the run ended because the budget was exhausted.
- clk_cnt_o  out  CNT_W  RUN cycles elapsed.
- event_cnt_o  out  EVT_W  Events counted.

Behaviour:
- Reset (reset_i=1 at a clk_i edge):
  - state=IDLE, dom_reset_n_o=0, all counters 0, running_o=0, done_o=0, timeout_o=0.
  - Applies mid-run too, aborting in 1 cycle.
- All outputs are registered.
- IDLE:
  - dom_reset_n_o=0.
  - start_i=1 → HOLD; the hold counter loads HOLD_CYC-1.
- HOLD:
  - Counts down; at 0 → RELEASE.
  - Domain 0 releases on the cycle HOLD ends, exactly HOLD_CYC cycles after start is sampled.
- RELEASE:
  - Domain k bit rises STAGGER_CYC cycles after domain k-1.
  - When the last domain is released → RUN on the next cycle.
  - Bits, once released, stay 1 until DONE or reset.
- RUN:
  - running_o=1.
  - clk_cnt_o increments every cycle with pause_i=0 and saturates at all-ones.
  - Budget check: if MAX_CYC≠0 and the incremented count == MAX_CYC → DONE and timeout_o=1.
  - stop_req_i=1 → DONE with timeout_o=0.
  - If stop_req_i and budget expiry occur in the same cycle, stop_req_i wins and timeout_o=0.
- event_cnt_o:
  - Increments on event_i in RELEASE and RUN regardless of pause_i; saturates at all-ones.
  - Ignored in IDLE, HOLD and DONE.
- DONE:
  - done_o=1; counters frozen; dom_reset_n_o held at all 1s so the DUT state stays observable.
  - start_i=1 → HOLD: counters clear, timeout_o clears, dom_reset_n_o drops to 0.
- start_i is ignored outside IDLE and DONE.
- stop_req_i in HOLD/RELEASE → DONE immediately. The domains not yet released stay 0 in DONE.
- NUM_DOM=1: RELEASE lasts 1 cycle.

Decomposition:
- Package sim_run_pkg holds:
  - the state typedef (IDLE, HOLD, RELEASE, RUN, DONE);
  - function sat_inc(value, width).
- One sub-module, sim_rst_stagger:
  - owns the hold/stagger counters and dom_reset_n_o;
  - reports all_released to the FSM.
- The FSM, counters and status stay in the top module.

Test Plan:
- Defaults: start at cycle 5 → dom_reset_n_o[0] rises at 15, [1] at 17, [2] at 19, [3] at 21; running_o=1 from 22; done_o=1, timeout_o=1, clk_cnt_o=60 at cycle 82.
- pause_i high for 7 cycles during RUN → done_o is delayed by exactly 7 cycles; clk_cnt_o=60 at finish.
- event_i high every other cycle during RELEASE and RUN with defaults → event_cnt_o=34 (RELEASE events plus 30 RUN events, per the alignment checked by the bench model); stop_req_i at clk_cnt_o=20 → done_o=1, timeout_o=0, clk_cnt_o=20.
- stop_req_i and budget expiry in the same cycle → timeout_o=0.
- reset_i asserted in RELEASE → next cycle: all outputs 0, state IDLE; a new start_i reproduces the scenario 1 timing.
- CNT_W=4, MAX_CYC=0 → clk_cnt_o saturates at 15 and never wraps; done_o stays 0. Restart from DONE → counters and timeout_o clear.

Source files
------------

// File: rtl/sim_run_pkg.sv
// Shared state encoding and helpers for the simulation run controller.
package sim_run_pkg;

  // Run-controller state type with legacy-compatible constant encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HOLD    = 3'd1;
  localparam state_t ST_RELEASE = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Control/status bundle between a simulation top and its run controller.
interface sim_run_ctrl_if #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 32,
  parameter int EVT_W   = 64
);
  logic               start_i;
  logic               pause_i;
  logic               event_i;
  logic               stop_req_i;
  logic [NUM_DOM-1:0] dom_reset_n_o;
  logic               running_o;
  logic               done_o;
  logic               timeout_o;
  logic [CNT_W-1:0]   clk_cnt_o;
  logic [EVT_W-1:0]   event_cnt_o;

  modport slave (
    input  start_i, pause_i, event_i, stop_req_i,
    output dom_reset_n_o, running_o, done_o, timeout_o, clk_cnt_o, event_cnt_o
  );

  modport master (
    output start_i, pause_i, event_i, stop_req_i,
    input  dom_reset_n_o, running_o, done_o, timeout_o, clk_cnt_o, event_cnt_o
  );
endinterface

// File: rtl/sim_rst_stagger.sv
// Hold timer and staggered per-domain reset release.
// load_i restarts the sequence with every domain in reset; adv_i lets the
// hold/stagger timers move (withheld on an early stop so released bits freeze).
module sim_rst_stagger #(
  parameter int NUM_DOM     = 4,
  parameter int HOLD_CYC    = 10,
  parameter int STAGGER_CYC = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               adv_i,
  output logic               hold_expire_o,
  output logic               all_released_o,
  output logic [NUM_DOM-1:0] dom_reset_n_o
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [SW-1:0] STAG_LOAD = (STAGGER_CYC > 0) ? SW'(STAGGER_CYC - 1) : '0;

  logic               holding_q, holding_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]      stag_cnt_q, stag_cnt_d;
  logic [NUM_DOM-1:0] rel_q, rel_d;

  assign hold_expire_o  = holding_q && (hold_cnt_q == '0);
  assign all_released_o = &rel_q;
  assign dom_reset_n_o  = rel_q;

  // Down-count the hold, then release domains one stagger interval apart.
  always_comb begin
    holding_d  = holding_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    rel_d      = rel_q;
    if (load_i) begin
      holding_d  = 1'b1;
      hold_cnt_d = HOLD_LOAD;
      stag_cnt_d = STAG_LOAD;
      rel_d      = '0;
    end else if (adv_i && holding_q) begin
      if (hold_cnt_q == '0) begin
        holding_d  = 1'b0;
        stag_cnt_d = STAG_LOAD;
        rel_d      = (STAGGER_CYC == 0) ? '1 : NUM_DOM'(1);
      end else begin
        hold_cnt_d = hold_cnt_q - HW'(1);
      end
    end else if (adv_i && rel_q[0] && !all_released_o) begin
      if (stag_cnt_q == '0) begin
        rel_d      = (rel_q << 1) | NUM_DOM'(1);
        stag_cnt_d = STAG_LOAD;
      end else begin
        stag_cnt_d = stag_cnt_q - SW'(1);
      end
    end
  end

  // Timer and release-bit registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      holding_q  <= 1'b0;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      rel_q      <= '0;
    end else begin
      holding_q  <= holding_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      rel_q      <= rel_d;
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller for simulation tops: staggered domain resets, cycle and
// event counting, and run termination on budget or stop request.
//
// state   | meaning
// IDLE    | waiting for start, all domains in reset
// HOLD    | all domains in reset for HOLD_CYC cycles
// RELEASE | domains leaving reset one stagger interval apart
// RUN     | counting run cycles against the budget
// DONE    | run finished, counters and domain resets frozen
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int          NUM_DOM     = 4,
  parameter int          HOLD_CYC    = 10,
  parameter int          STAGGER_CYC = 2,
  parameter int          CNT_W       = 32,
  parameter int          EVT_W       = 64,
  parameter int unsigned MAX_CYC     = 60
) (
  input logic            clk_i,
  input logic            reset_i,
  sim_run_ctrl_if.slave  bus
);

  // A budget wider than the counter can never be reached, so it is disabled.
  localparam bit               MAX_OK = (MAX_CYC != 0) && ((64'(MAX_CYC) >> CNT_W) == 64'd0);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d, clk_inc;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d, evt_inc;
  logic             timeout_q, timeout_d;
  logic             running_q, done_q;
  logic             load, adv, hold_expire, all_released;

  assign clk_inc = CNT_W'(sat_inc(64'(clk_cnt_q), CNT_W));
  assign evt_inc = EVT_W'(sat_inc(64'(evt_cnt_q), EVT_W));
  assign adv     = ((state_q == ST_HOLD) || (state_q == ST_RELEASE)) && !bus.stop_req_i;

  sim_rst_stagger #(
    .NUM_DOM    (NUM_DOM),
    .HOLD_CYC   (HOLD_CYC),
    .STAGGER_CYC(STAGGER_CYC)
  ) u_stagger (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .load_i        (load),
    .adv_i         (adv),
    .hold_expire_o (hold_expire),
    .all_released_o(all_released),
    .dom_reset_n_o (bus.dom_reset_n_o)
  );

  // Run sequencing, counter updates and termination decisions.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    evt_cnt_d = evt_cnt_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.stop_req_i)    state_d = ST_DONE;
        else if (hold_expire)  state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (bus.event_i) evt_cnt_d = evt_inc;
        if (bus.stop_req_i)    state_d = ST_DONE;
        else if (all_released) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.event_i) evt_cnt_d = evt_inc;
        if (bus.stop_req_i) begin
          state_d = ST_DONE;
        end else if (!bus.pause_i) begin
          clk_cnt_d = clk_inc;
          if (MAX_OK && (clk_inc == MAX_V)) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.start_i) begin
          load      = 1'b1;
          state_d   = ST_HOLD;
          clk_cnt_d = '0;
          evt_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      evt_cnt_q <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      evt_cnt_q <= evt_cnt_d;
      timeout_q <= timeout_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.running_o   = running_q;
  assign bus.done_o      = done_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.clk_cnt_o   = clk_cnt_q;
  assign bus.event_cnt_o = evt_cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: a default-parameter instance and a small
// saturating instance share one stimulus stream and are compared every
// cycle against a timeline model (elapsed cycles since start).
module tb_sim_run_ctrl;

  localparam int ND0 = 4, H0 = 10, S0 = 2, CW0 = 32, EW0 = 64, M0 = 60;
  localparam int ND1 = 3, H1 = 3,  S1 = 0, CW1 = 4,  EW1 = 4,  M1 = 0;
  localparam int W0 = ND0 + 3 + CW0 + EW0;
  localparam int W1 = ND1 + 3 + CW1 + EW1;

  typedef struct packed {
    bit          active;
    bit          running;
    bit          done;
    bit          timeout;
    logic [31:0] t;
    logic [15:0] rel;
    logic [63:0] clk;
    logic [63:0] evt;
  } ms_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pause = 1'b0, evt = 1'b0, stop = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ms_t  m0 = '0, m1 = '0;

  always #5 clk = ~clk;

  sim_run_ctrl_if #(.NUM_DOM(ND0), .CNT_W(CW0), .EVT_W(EW0)) bus0 ();
  sim_run_ctrl_if #(.NUM_DOM(ND1), .CNT_W(CW1), .EVT_W(EW1)) bus1 ();

  assign bus0.start_i = start;  assign bus1.start_i = start;
  assign bus0.pause_i = pause;  assign bus1.pause_i = pause;
  assign bus0.event_i = evt;    assign bus1.event_i = evt;
  assign bus0.stop_req_i = stop; assign bus1.stop_req_i = stop;

  sim_run_ctrl #(.NUM_DOM(ND0), .HOLD_CYC(H0), .STAGGER_CYC(S0), .CNT_W(CW0), .EVT_W(EW0), .MAX_CYC(M0))
    dut0 (.clk_i(clk), .reset_i(rst), .bus(bus0));
  sim_run_ctrl #(.NUM_DOM(ND1), .HOLD_CYC(H1), .STAGGER_CYC(S1), .CNT_W(CW1), .EVT_W(EW1), .MAX_CYC(M1))
    dut1 (.clk_i(clk), .reset_i(rst), .bus(bus1));

  logic [W0-1:0] obs0;
  logic [W1-1:0] obs1;
  assign obs0 = {bus0.dom_reset_n_o, bus0.running_o, bus0.done_o, bus0.timeout_o, bus0.clk_cnt_o, bus0.event_cnt_o};
  assign obs1 = {bus1.dom_reset_n_o, bus1.running_o, bus1.done_o, bus1.timeout_o, bus1.clk_cnt_o, bus1.event_cnt_o};

  // Reference: the run is a timeline measured in cycles t since start.
  // Domain k is out of reset once t >= hold + k*stag; RUN begins the cycle
  // after the last release; budget/stop end the run.
  function automatic ms_t mstep(input ms_t m, input int nd, input int hold, input int stag,
                                input int maxc, input int cw, input int ew,
                                input bit r, input bit st, input bit pa, input bit ev, input bit sp);
    ms_t n;
    int last_rel;
    logic [63:0] cmax, emax;
    n = m;
    last_rel = hold + (nd - 1) * stag;
    cmax = (cw >= 64) ? '1 : ((64'd1 << cw) - 64'd1);
    emax = (ew >= 64) ? '1 : ((64'd1 << ew) - 64'd1);
    if (r) return '0;
    if (!m.active) begin
      if (st) begin
        n = '0;
        n.active = 1'b1;
      end
      return n;
    end
    if (int'(m.t) >= hold && ev && m.evt != emax) n.evt = m.evt + 64'd1;
    if (sp) begin
      n.active = 1'b0; n.done = 1'b1; n.running = 1'b0;
      return n;
    end
    if (int'(m.t) > last_rel && !pa) begin
      if (m.clk != cmax) n.clk = m.clk + 64'd1;
      if (maxc != 0 && n.clk == 64'(maxc)) begin
        n.active = 1'b0; n.done = 1'b1; n.running = 1'b0; n.timeout = 1'b1;
        return n;
      end
    end
    n.t = m.t + 32'd1;
    for (int k = 0; k < nd; k++) n.rel[k] = (int'(n.t) >= hold + k * stag);
    n.running = (int'(n.t) > last_rel);
    return n;
  endfunction

  function automatic logic [W0-1:0] exp0(input ms_t m);
    return {m.rel[ND0-1:0], m.running, m.done, m.timeout, m.clk[CW0-1:0], m.evt[EW0-1:0]};
  endfunction

  function automatic logic [W1-1:0] exp1(input ms_t m);
    return {m.rel[ND1-1:0], m.running, m.done, m.timeout, m.clk[CW1-1:0], m.evt[EW1-1:0]};
  endfunction

  // One clock: inputs present at the edge feed both DUTs and both models.
  task automatic step();
    bit r, st, pa, ev, sp;
    r = rst; st = start; pa = pause; ev = evt; sp = stop;
    @(posedge clk);
    #1;
    m0 = mstep(m0, ND0, H0, S0, M0, CW0, EW0, r, st, pa, ev, sp);
    m1 = mstep(m1, ND1, H1, S1, M1, CW1, EW1, r, st, pa, ev, sp);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; evt = 1'b0; stop = 1'b0;
    step(); step();
    checks++; if (obs0 !== '0) begin errors++; $display("FAIL reset0 got %h exp 0", obs0); end
    checks++; if (obs1 !== '0) begin errors++; $display("FAIL reset1 got %h exp 0", obs1); end
    rst = 1'b0;
    step();
    checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL idle0 got %h exp %h", obs0, exp0(m0)); end
  endtask

  task automatic test_timing();
    int e, t_run, t_done;
    int t_rel[ND0];
    for (int k = 0; k < ND0; k++) t_rel[k] = -1;
    t_run = -1; t_done = -1;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    e = cyc;
    for (int i = 0; i < 120 && t_done < 0; i++) begin
      step();
      checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL timing_c%0d got %h exp %h", cyc, obs0, exp0(m0)); end
      for (int k = 0; k < ND0; k++) if (t_rel[k] < 0 && bus0.dom_reset_n_o[k]) t_rel[k] = cyc;
      if (t_run < 0 && bus0.running_o) t_run = cyc;
      if (bus0.done_o) t_done = cyc;
    end
    for (int k = 0; k < ND0; k++) begin
      checks++; if (t_rel[k] != e + 10 + 2 * k) begin errors++; $display("FAIL rel%0d_time got %0d exp %0d", k, t_rel[k], e + 10 + 2 * k); end
    end
    checks++; if (t_run != e + 17) begin errors++; $display("FAIL run_time got %0d exp %0d", t_run, e + 17); end
    checks++; if (t_done != e + 77) begin errors++; $display("FAIL done_time got %0d exp %0d", t_done, e + 77); end
    checks++; if (bus0.clk_cnt_o !== 32'd60 || bus0.timeout_o !== 1'b1)
      begin errors++; $display("FAIL budget_end got cnt %0d to %b exp 60 1", bus0.clk_cnt_o, bus0.timeout_o); end
  endtask

  task automatic test_pause();
    int e, t_done;
    t_done = -1;
    start = 1'b1; step(); start = 1'b0;
    e = cyc;
    for (int i = 0; i < 140 && t_done < 0; i++) begin
      evt = 1'($urandom_range(0, 1));
      pause = (i >= 27 && i < 34);
      step();
      checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL pause_c%0d got %h exp %h", cyc, obs0, exp0(m0)); end
      if (bus0.done_o) t_done = cyc;
    end
    pause = 1'b0; evt = 1'b0;
    checks++; if (t_done != e + 84) begin errors++; $display("FAIL pause_done_time got %0d exp %0d", t_done, e + 84); end
    checks++; if (bus0.clk_cnt_o !== 32'd60 || bus0.timeout_o !== 1'b1)
      begin errors++; $display("FAIL pause_end got cnt %0d to %b exp 60 1", bus0.clk_cnt_o, bus0.timeout_o); end
  endtask

  task automatic test_restart_and_hold_stop();
    start = 1'b1; step(); start = 1'b0;
    checks++; if (obs0 !== '0) begin errors++; $display("FAIL restart_clear got %h exp 0", obs0); end
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (bus0.done_o !== 1'b1 || bus0.dom_reset_n_o !== 4'b0000 || bus0.timeout_o !== 1'b0)
      begin errors++; $display("FAIL hold_stop got done %b dom %b to %b exp 1 0000 0", bus0.done_o, bus0.dom_reset_n_o, bus0.timeout_o); end
    checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL hold_stop_model got %h exp %h", obs0, exp0(m0)); end
  endtask

  task automatic test_stop_at(input int target, input string tag);
    bit fin;
    fin = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      evt = ~evt;
      step();
      checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL %s_c%0d got %h exp %h", tag, cyc, obs0, exp0(m0)); end
      if (stop) fin = 1'b1;
      else if (bus0.running_o && bus0.clk_cnt_o == 32'(target)) stop = 1'b1;
    end
    stop = 1'b0; evt = 1'b0;
    checks++; if (bus0.done_o !== 1'b1 || bus0.timeout_o !== 1'b0 || bus0.clk_cnt_o !== 32'(target))
      begin errors++; $display("FAIL %s_end got done %b to %b cnt %0d exp 1 0 %0d", tag, bus0.done_o, bus0.timeout_o, bus0.clk_cnt_o, target); end
  endtask

  task automatic test_reset_release();
    int e, t_run;
    int t_rel[ND0];
    for (int k = 0; k < ND0; k++) t_rel[k] = -1;
    t_run = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40 && !bus0.dom_reset_n_o[1]; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (obs0 !== '0) begin errors++; $display("FAIL mid_reset got %h exp 0", obs0); end
    step();
    start = 1'b1; step(); start = 1'b0;
    e = cyc;
    for (int i = 0; i < 40 && t_run < 0; i++) begin
      step();
      checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL rerun_c%0d got %h exp %h", cyc, obs0, exp0(m0)); end
      for (int k = 0; k < ND0; k++) if (t_rel[k] < 0 && bus0.dom_reset_n_o[k]) t_rel[k] = cyc;
      if (bus0.running_o) t_run = cyc;
    end
    for (int k = 0; k < ND0; k++) begin
      checks++; if (t_rel[k] != e + 10 + 2 * k) begin errors++; $display("FAIL rerel%0d_time got %0d exp %0d", k, t_rel[k], e + 10 + 2 * k); end
    end
    checks++; if (t_run != e + 17) begin errors++; $display("FAIL rerun_time got %0d exp %0d", t_run, e + 17); end
  endtask

  task automatic test_saturate();
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    evt = 1'b1;
    repeat (40) begin
      step();
      checks++; if (obs1 !== exp1(m1)) begin errors++; $display("FAIL sat_c%0d got %h exp %h", cyc, obs1, exp1(m1)); end
    end
    evt = 1'b0;
    checks++; if (bus1.clk_cnt_o !== 4'd15 || bus1.event_cnt_o !== 4'd15 || bus1.done_o !== 1'b0 || bus1.running_o !== 1'b1)
      begin errors++; $display("FAIL sat_end got cnt %0d evt %0d done %b run %b exp 15 15 0 1", bus1.clk_cnt_o, bus1.event_cnt_o, bus1.done_o, bus1.running_o); end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (bus1.done_o !== 1'b1 || bus1.clk_cnt_o !== 4'd15)
      begin errors++; $display("FAIL sat_stop got done %b cnt %0d exp 1 15", bus1.done_o, bus1.clk_cnt_o); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (obs1 !== '0) begin errors++; $display("FAIL sat_restart got %h exp 0", obs1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      pause = ($urandom_range(0, 3) == 0);
      evt   = 1'($urandom_range(0, 1));
      step();
      checks++; if (obs0 !== exp0(m0)) begin errors++; $display("FAIL rand0_c%0d got %h exp %h", cyc, obs0, exp0(m0)); end
      checks++; if (obs1 !== exp1(m1)) begin errors++; $display("FAIL rand1_c%0d got %h exp %h", cyc, obs1, exp1(m1)); end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; evt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pause();
    test_restart_and_hold_stop();
    test_stop_at(20, "stop20");
    test_stop_at(59, "stop_vs_budget");
    test_reset_release();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
